// File: rtl/ads_pkg.sv
// ads_pkg: shared state encoding, ADS command words and frame helpers for the scan controller.
package ads_pkg;

    typedef enum logic [2:0] {
        CFG_SEND,
        CFG_WAIT,
        IDLE,
        SCAN_SEND,
        SCAN_WAIT,
        HOST_SEND,
        HOST_WAIT
    } state_t;

    localparam int N_CH = 4;

    localparam logic [15:0] CMD_MAN_CH0 = 16'hC000;
    localparam logic [15:0] CMD_MAN_CH1 = 16'hC400;
    localparam logic [15:0] CMD_MAN_CH2 = 16'hC800;
    localparam logic [15:0] CMD_MAN_CH3 = 16'hCC00;
    localparam logic [15:0] CMD_NO_OP   = 16'h0000;

    // Range registers 05h-08h written with 00h
    localparam logic [15:0] CFG_WORD [4] = '{16'h0B00, 16'h0D00, 16'h0F00, 16'h1100};

    // Frames 0..N_CH-1 select channels in turn; the last frame only clocks out ch3
    function automatic logic [15:0] scan_word(input logic [2:0] f);
        return f < 3'(N_CH) ? (CMD_MAN_CH0 | {4'b0, f[1:0], 10'b0}) : CMD_NO_OP;
    endfunction

endpackage

// File: rtl/ads_tick_gen.sv
// ads_tick_gen: periodic scan tick, pending-request flag and saturating overrun counter.
module ads_tick_gen
    import ads_pkg::*;
#(
    parameter int PERIOD = 2500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scan_en,
    input  logic       clr,
    output logic       tick_pend,
    output logic [7:0] overrun_cnt
);

    localparam int CW = $clog2(PERIOD);

    logic [CW-1:0] cnt;
    logic          wrap;

    assign wrap = scan_en && cnt == CW'(PERIOD - 1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= '0;
            tick_pend   <= 1'b0;
            overrun_cnt <= 8'd0;
        end else begin
            cnt       <= (!scan_en || wrap) ? '0 : cnt + 1'b1;
            tick_pend <= wrap || (tick_pend && !clr);
            // A tick landing on the cycle the pending one is consumed is not lost
            if (wrap && tick_pend && !clr && overrun_cnt != 8'hFF)
                overrun_cnt <= overrun_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/ads_scan_ctrl.sv
// ads_scan_ctrl: ADS ADC sequencer - config after reset, periodic 4-channel scan with
// one-frame-late response demux, and host register access sharing the single SPI master.
module ads_scan_ctrl
    import ads_pkg::*;
#(
    parameter int SAMPLE_PERIOD = 2500,
    parameter int TIMEOUT       = 1023,
    parameter int CFG_EN        = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scan_en,
    output logic        spi_start,
    output logic [15:0] spi_tx_data,
    input  logic        spi_done,
    input  logic [15:0] spi_rx_data,
    input  logic        host_req,
    input  logic [15:0] host_wr_word,
    output logic        host_ack,
    output logic [15:0] host_rd_word,
    output logic [15:0] ch_data,
    output logic [1:0]  ch_id,
    output logic        ch_valid,
    output logic [15:0] pkg_num,
    output logic        busy,
    output logic        timeout_err,
    output logic [7:0]  overrun_cnt
);

    state_t      state;
    logic [1:0]  cfg_idx;
    logic [2:0]  frame;
    logic [15:0] wcnt;
    logic        tick_pend;
    logic        scan_go;
    logic        waiting;

    assign scan_go = state == IDLE && tick_pend;
    assign waiting = state == CFG_WAIT || state == SCAN_WAIT || state == HOST_WAIT;

    ads_tick_gen #(.PERIOD(SAMPLE_PERIOD)) u_tick (
        .clk         (clk),
        .rst_n       (rst_n),
        .scan_en     (scan_en),
        .clr         (scan_go),
        .tick_pend   (tick_pend),
        .overrun_cnt (overrun_cnt)
    );

    // spi_start is raised on entry to a SEND state so it is high for that state's only cycle;
    // the one entry with no predecessor (out of reset) raises it from within CFG_SEND instead.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= CFG_EN != 0 ? CFG_SEND : IDLE;
            cfg_idx      <= 2'd0;
            frame        <= 3'd0;
            wcnt         <= 16'd0;
            spi_start    <= 1'b0;
            spi_tx_data  <= 16'd0;
            host_ack     <= 1'b0;
            host_rd_word <= 16'd0;
            ch_data      <= 16'd0;
            ch_id        <= 2'd0;
            ch_valid     <= 1'b0;
            pkg_num      <= 16'd0;
            busy         <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            spi_start <= 1'b0;
            ch_valid  <= 1'b0;
            host_ack  <= 1'b0;
            wcnt      <= wcnt + 16'd1;
            case (state)
                CFG_SEND, SCAN_SEND, HOST_SEND: begin
                    busy <= 1'b1;
                    if (spi_start) begin
                        state <= state == CFG_SEND ? CFG_WAIT : state == SCAN_SEND ? SCAN_WAIT : HOST_WAIT;
                        wcnt  <= 16'd1;
                    end else begin
                        spi_start   <= 1'b1;
                        spi_tx_data <= state == CFG_SEND ? CFG_WORD[cfg_idx] :
                                       state == SCAN_SEND ? scan_word(frame) : host_wr_word;
                    end
                end
                CFG_WAIT: if (spi_done) begin
                    pkg_num <= pkg_num + 16'd1;
                    cfg_idx <= cfg_idx + 2'd1;
                    if (cfg_idx == 2'd3) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state       <= CFG_SEND;
                        spi_start   <= 1'b1;
                        spi_tx_data <= CFG_WORD[cfg_idx + 2'd1];
                    end
                end
                IDLE: if (tick_pend) begin
                    state       <= SCAN_SEND;
                    frame       <= 3'd0;
                    spi_start   <= 1'b1;
                    spi_tx_data <= scan_word(3'd0);
                    pkg_num     <= 16'd0;
                    busy        <= 1'b1;
                end else if (host_req) begin
                    state       <= HOST_SEND;
                    spi_start   <= 1'b1;
                    spi_tx_data <= host_wr_word;
                    pkg_num     <= 16'd0;
                    busy        <= 1'b1;
                end
                SCAN_WAIT: if (spi_done) begin
                    pkg_num <= pkg_num + 16'd1;
                    frame   <= frame + 3'd1;
                    // Frame k returns the channel selected by frame k-1
                    if (frame != 3'd0) begin
                        ch_valid <= 1'b1;
                        ch_data  <= spi_rx_data;
                        ch_id    <= frame[1:0] - 2'd1;
                    end
                    if (frame == 3'(N_CH)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state       <= SCAN_SEND;
                        spi_start   <= 1'b1;
                        spi_tx_data <= scan_word(frame + 3'd1);
                    end
                end
                HOST_WAIT: if (spi_done) begin
                    pkg_num      <= pkg_num + 16'd1;
                    host_ack     <= 1'b1;
                    host_rd_word <= spi_rx_data;
                    state        <= IDLE;
                    busy         <= 1'b0;
                end
                default: state <= IDLE;
            endcase
            // wcnt holds cycles since spi_start; a late spi_done still wins the tie
            if (waiting && !spi_done && wcnt == 16'(TIMEOUT - 1)) begin
                timeout_err <= 1'b1;
                state       <= IDLE;
                busy        <= 1'b0;
            end
        end
    end

endmodule

// File: doc/ads_scan_ctrl.md
Name: ads_scan_ctrl

Overview:
- Sequences the ADS multichannel ADC serial interface, and owns the only SPI master (start/done handshake).
- After reset it sends a fixed 4-word range configuration. It then runs a periodic 4-channel manual-select scan and demuxes the pipelined responses into per-channel samples.
- It shares the SPI master with a host register-access requester. Scan ticks have priority.

Parameters:
- SAMPLE_PERIOD, 2500: clk cycles between scan ticks (min 16).
- TIMEOUT, 1023: max clk cycles from spi_start to spi_done before abort.
- CFG_EN, 1: 1 = send the configuration sequence after reset; 0 = go straight to IDLE.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low
- scan_en  in  1  1 = the periodic tick counter runs
- spi_start  out  1  one-cycle pulse; spi_tx_data is valid in the same cycle
- spi_tx_data  out  16  command word for the frame
- spi_done  in  1  one-cycle pulse at frame end; spi_rx_data is valid in the same cycle
- spi_rx_data  in  16  word received in the frame
- host_req  in  1  level; held until host_ack
- host_wr_word  in  16  raw command word from the host
- host_ack  out  1  one-cycle pulse; host_rd_word is valid in the same cycle
- host_rd_word  out  16  response word
- ch_data  out  16  channel sample
- ch_id  out  2  channel index of ch_data
- ch_valid  out  1  one-cycle strobe
- pkg_num  out  16  frame index within the current transaction
- busy  out  1  state is not IDLE
- timeout_err  out  1  sticky flag
- overrun_cnt  out  8  saturating count of dropped ticks

Behaviour:
- Reset (rst_n=0 at a clk edge) clears all outputs, counters, pending flags and timeout_err to 0. The state goes to CFG_SEND if CFG_EN=1, else IDLE. Reset mid-frame abandons the frame with no ack or strobe.
- States:
  - CFG_SEND -> CFG_WAIT: issue the config word selected by cfg_idx.
  - CFG_WAIT: on spi_done, cfg_idx++. If cfg_idx was 3, go to IDLE, else back to CFG_SEND.
  - IDLE:
    - tick_pend -> SCAN_SEND, with frame=0.
    - Else host_req -> HOST_SEND.
  - SCAN_SEND -> SCAN_WAIT.
  - SCAN_WAIT: on spi_done, frame++. If frame was 4, go to IDLE, else back to SCAN_SEND.
  - HOST_SEND -> HOST_WAIT.
  - HOST_WAIT: on spi_done, go to IDLE.
- *_SEND states assert spi_start for exactly 1 cycle and load spi_tx_data.
- Scan frame words, frames 0..4: CMD_MAN_CH0, CH1, CH2, CH3, CMD_NO_OP.
- The response is one frame late:
  - The rx of frame k (k=1..4) is sample ch(k-1).
  - On that spi_done, the next cycle gives ch_data=spi_rx_data, ch_id=k-1, ch_valid=1.
  - The rx of frame 0 is discarded.
- Host transaction:
  - spi_tx_data=host_wr_word.
  - On spi_done, the next cycle gives host_ack=1 and host_rd_word=spi_rx_data.
- pkg_num:
  - Cleared to 0 when a transaction starts (scan, host, or the config sequence).
  - Increments on each spi_done within the transaction.
  - Holds after the transaction ends.
- Tick counter:
  - Counts 0..SAMPLE_PERIOD-1 while scan_en=1 and wraps; the wrap sets tick_pend.
  - scan_en=0 clears the counter and holds it at 0.
  - A tick while tick_pend=1 increments overrun_cnt, saturating at 255.
  - tick_pend clears on IDLE->SCAN_SEND. A tick in that same cycle re-sets it, so the set wins.
- Arbitration:
  - Evaluated only in IDLE; a transaction in flight is never preempted.
  - Tick and host_req in the same cycle: scan first, host on the next IDLE.
- Timeout:
  - A wait counter resets on spi_start and counts in *_WAIT states.
  - Reaching TIMEOUT sets timeout_err=1 and goes to IDLE.
  - An aborted scan emits no further ch_valid. An aborted host transaction emits no host_ack.
  - An aborted config sequence is not retried.
  - timeout_err clears only on reset.
- spi_done outside a *_WAIT state is ignored.
- Latency: tick_pend set to the first spi_start is 1 cycle. IDLE to spi_start is 1 cycle.

Decomposition:
- Package ads_pkg:
  - state enum.
  - CMD_MAN_CH0..CH3 = 16'hC000, C400, C800, CC00.
  - CMD_NO_OP = 16'h0000.
  - CFG_WORD[0..3] = 16'h0B00, 0D00, 0F00, 1100 (range regs 05h-08h = 00h).
  - N_CH = 4.
- Sub-module ads_tick_gen: tick counter, pending flag and overrun counter. The FSM stays in the top level.

Test Plan:
1. Reset with CFG_EN=1; the SPI model answers each frame 20 cycles after start -> 4 spi_start pulses with tx 0B00, 0D00, 0F00, 1100; pkg_num ends at 4; busy ends at 0.
2. scan_en=1, SAMPLE_PERIOD=100; model rx for frames 0..4 = 0000, 1111, 2222, 3333, 4444 -> 5 frames with tx C000, C400, C800, CC00, 0000; ch_valid x4 with (ch_id, ch_data) = (0,1111), (1,2222), (2,3333), (3,4444).
3. host_req with host_wr_word=16'h0A00 in the same cycle as a tick -> the scan completes first; then one frame with tx 0A00; host_ack once with host_rd_word equal to the model rx.
4. Model never returns spi_done in frame 2 of a scan -> timeout_err=1 exactly TIMEOUT cycles after that spi_start; FSM in IDLE; only ch_valid for ch0 seen; the next tick scans normally.
5. SAMPLE_PERIOD=16; model latency 30 cycles/frame -> overrun_cnt increments on each tick arriving while tick_pend=1; it saturates at 255 in a long run.
6. Assert rst_n=0 during SCAN_WAIT frame 3 -> the next cycle has all outputs 0; no ch_valid or host_ack; the config sequence restarts after release.
